// File: rtl/stream_order_checker.sv
// Packet-stream order checker: flags packets whose beats are not
// non-decreasing, plus framing and length errors, with result counters.
module stream_order_checker #(
  parameter int DWIDTH      = 64,
  parameter int MAX_PKT_LEN = 128
) (
  input  logic                               clk_i,
  input  logic                               arst_i,
  input  logic [DWIDTH-1:0]                  snk_data_i,
  input  logic                               snk_startofpacket_i,
  input  logic                               snk_endofpacket_i,
  input  logic                               snk_valid_i,
  output logic                               snk_ready_o,
  output logic                               res_valid_o,
  output logic                               res_sorted_o,
  output logic                               res_err_o,
  output logic [$clog2(MAX_PKT_LEN+1)-1:0]   res_len_o,
  output logic [15:0]                        pkt_cnt_o,
  output logic [15:0]                        err_cnt_o
);

  localparam int LW = $clog2(MAX_PKT_LEN+1);
  localparam logic [LW-1:0] LEN_ONE = LW'(1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_PKT_LEN);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECV   = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  logic [1:0]        r_state;
  logic              r_live;
  logic [LW-1:0]     r_len;
  logic [DWIDTH-1:0] r_prev;
  logic              r_sorted;
  logic              r_err;
  logic              r_pend;
  logic              r_res_valid;
  logic              r_res_sorted;
  logic              r_res_err;
  logic [LW-1:0]     r_res_len;
  logic [15:0]       r_pkt_cnt;
  logic [15:0]       r_err_cnt;

  logic [1:0]        w_state;
  logic [LW-1:0]     w_len;
  logic [DWIDTH-1:0] w_prev;
  logic              w_sorted;
  logic              w_err;
  logic              w_pend;
  logic              w_fire;
  logic              w_f_sorted;
  logic              w_f_err;
  logic [LW-1:0]     w_f_len;
  logic              w_drop;
  logic              w_acc;
  logic              w_len_max;
  logic [LW-1:0]     w_len_inc;
  logic              w_sorted_nx;
  logic              w_err_nx;
  logic              w_bump_err;

  assign snk_ready_o = r_live && (r_state != S_REPORT);
  assign w_acc       = snk_valid_i && snk_ready_o;
  assign w_len_max   = (r_len == LEN_MAX);
  assign w_len_inc   = w_len_max ? r_len : r_len + LEN_ONE;
  assign w_sorted_nx = r_sorted && !(snk_data_i < r_prev);
  assign w_err_nx    = r_err || w_len_max;

  always_comb begin
    w_state    = r_state;
    w_len      = r_len;
    w_prev     = r_prev;
    w_sorted   = r_sorted;
    w_err      = r_err;
    w_pend     = r_pend;
    w_fire     = 1'b0;
    w_f_sorted = 1'b1;
    w_f_err    = 1'b0;
    w_f_len    = LEN_ONE;
    w_drop     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (!snk_startofpacket_i) begin
            w_drop = 1'b1;
          end else begin
            w_len    = LEN_ONE;
            w_prev   = snk_data_i;
            w_sorted = 1'b1;
            w_err    = 1'b0;
            w_fire   = snk_endofpacket_i;
            w_state  = snk_endofpacket_i ? S_REPORT : S_RECV;
          end
        end
      end
      S_RECV: begin
        if (w_acc && snk_startofpacket_i) begin
          // Premature SOP closes the open packet and restarts on this beat
          w_fire     = 1'b1;
          w_f_sorted = r_sorted;
          w_f_err    = 1'b1;
          w_f_len    = r_len;
          w_len      = LEN_ONE;
          w_prev     = snk_data_i;
          w_sorted   = 1'b1;
          w_err      = 1'b0;
          if (snk_endofpacket_i) begin
            w_state = S_REPORT;
            w_pend  = 1'b1;
          end
        end else if (w_acc) begin
          w_len    = w_len_inc;
          w_prev   = snk_data_i;
          w_sorted = w_sorted_nx;
          w_err    = w_err_nx;
          if (snk_endofpacket_i) begin
            w_fire     = 1'b1;
            w_f_sorted = w_sorted_nx;
            w_f_err    = w_err_nx;
            w_f_len    = w_len_inc;
            w_state    = S_REPORT;
          end
        end
      end
      S_REPORT: begin
        w_state = S_IDLE;
        // Pending single-beat packet queued behind a forced close
        if (r_pend) begin
          w_fire = 1'b1;
          w_pend = 1'b0;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign w_bump_err = w_drop || (w_fire && (w_f_err || !w_f_sorted));

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state      <= S_IDLE;
      r_live       <= 1'b0;
      r_len        <= '0;
      r_prev       <= '0;
      r_sorted     <= 1'b0;
      r_err        <= 1'b0;
      r_pend       <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_sorted <= 1'b0;
      r_res_err    <= 1'b0;
      r_res_len    <= '0;
      r_pkt_cnt    <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_state     <= w_state;
      r_live      <= 1'b1;
      r_len       <= w_len;
      r_prev      <= w_prev;
      r_sorted    <= w_sorted;
      r_err       <= w_err;
      r_pend      <= w_pend;
      r_res_valid <= w_fire;
      if (w_fire) begin
        r_res_sorted <= w_f_sorted;
        r_res_err    <= w_f_err;
        r_res_len    <= w_f_len;
      end
      if (w_fire && r_pkt_cnt != 16'hFFFF)
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (w_bump_err && r_err_cnt != 16'hFFFF)
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign res_valid_o  = r_res_valid;
  assign res_sorted_o = r_res_sorted;
  assign res_err_o    = r_res_err;
  assign res_len_o    = r_res_len;
  assign pkt_cnt_o    = r_pkt_cnt;
  assign err_cnt_o    = r_err_cnt;

endmodule

// File: doc/stream_order_checker.md
STREAM_ORDER_CHECKER -- requirements
Module: stream_order_checker

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, beat data width in bits.
REQ-002 SHALL have parameter MAX_PKT_LEN, default 128, maximum legal beats per packet.
REQ-003 SHALL have clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have arst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have snk_data_i  input  DWIDTH  beat data.
REQ-006 SHALL have snk_startofpacket_i  input  1  first beat of packet.
REQ-007 SHALL have snk_endofpacket_i  input  1  last beat of packet.
REQ-008 SHALL have snk_valid_i  input  1  beat present.
REQ-009 SHALL have snk_ready_o  output  1  checker accepts beat this cycle.
REQ-010 SHALL have res_valid_o  output  1  one-cycle result strobe.
REQ-011 SHALL have res_sorted_o  output  1  packet non-decreasing (unsigned).
REQ-012 SHALL have res_err_o  output  1  framing or length error in packet.
REQ-013 SHALL have res_len_o  output  $clog2(MAX_PKT_LEN+1)  accepted beat count, saturating at MAX_PKT_LEN.
REQ-014 SHALL have pkt_cnt_o  output  16  results issued, saturating at 16'hFFFF.
REQ-015 SHALL have err_cnt_o  output  16  error events, saturating at 16'hFFFF.

Function
REQ-016 SHALL accept a beat only on a rising edge where snk_valid_i && snk_ready_o; snk_data_i/SOP/EOP are don't-care otherwise.
REQ-017 SHALL implement FSM states IDLE, RECV, REPORT; snk_ready_o = 1 in IDLE and RECV, 0 in REPORT.
REQ-018 IDLE: accepted beat with SOP and no EOP -> RECV with len=1, prev=data, sorted=1, err=0.
REQ-019 IDLE: accepted beat with SOP and EOP -> REPORT with len=1, sorted=1, err=0.
REQ-020 IDLE: accepted beat without SOP SHALL be dropped, produce no result, increment err_cnt_o; stay IDLE.
REQ-021 RECV: accepted non-SOP beat -> len+1 (saturating), sorted cleared if data < prev (unsigned; equal keeps sorted), prev=data.
REQ-022 RECV: beat raising count above MAX_PKT_LEN SHALL set err; checker keeps consuming until EOP, res_len_o reports MAX_PKT_LEN.
REQ-023 RECV: accepted non-SOP beat with EOP -> REPORT.
REQ-024 RECV: accepted beat with SOP SHALL close the current packet as a result with res_err_o=1 (res_valid_o next cycle, no ready bubble) and start a new packet from that beat per REQ-018/019.
REQ-025 REPORT lasts exactly one cycle then -> IDLE; no beat accepted in REPORT.
REQ-026 res_valid_o SHALL be high for exactly the one cycle after the edge accepting EOP (or closing SOP per REQ-024); res_sorted_o, res_err_o, res_len_o valid only in that cycle and registered.
REQ-027 Per result: pkt_cnt_o +1; err_cnt_o +1 if res_err_o or !res_sorted_o; REQ-020 and result increments in one cycle SHALL not both occur (disjoint states).
REQ-028 Single-beat packet SHALL report sorted=1, len=1.

Reset
REQ-029 While arst_i high: state IDLE; snk_ready_o, res_valid_o, res_sorted_o, res_err_o = 0; res_len_o, pkt_cnt_o, err_cnt_o = 0; snk_ready_o = 1 from first edge after release.
REQ-030 Reset mid-packet SHALL discard the packet with no result and no counter change beyond clearing.

Verification
REQ-031 Packet 1,2,2,5 (SOP first, EOP last, valid gaps random) -> one res_valid_o pulse, sorted=1, err=0, len=4, pkt_cnt_o=1.
REQ-032 Packet 10,9,...,1 -> sorted=0, len=10, err_cnt_o +1; snk_ready_o low exactly the cycle after EOP.
REQ-033 Single beat SOP+EOP value 7 -> sorted=1, len=1 one cycle later.
REQ-034 Beats 3,4 (no EOP) then SOP 1 + EOP -> two results: first err=1 len=2, second err=0 len=1, both valid on consecutive result cycles without stray drop.
REQ-035 MAX_PKT_LEN+3 ascending beats -> err=1, len=MAX_PKT_LEN; stray non-SOP beat in IDLE -> no result, err_cnt_o +1.
REQ-036 arst_i pulsed mid-packet (asynchronous to clk_i) -> all outputs 0 immediately, next full packet reports correctly with pkt_cnt_o=1.
